// File: rtl/rgb_byte_serializer.sv
// Pixel FIFO feeding an R,G,B byte serializer with a valid/ready output handshake.
// The upstream pixel stream cannot stall, so pixels arriving at a full FIFO are dropped and flagged.
module rgb_byte_serializer #(
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [23:0]              rgb_in,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic                     byte_last
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AFULL_L = (AW + 1)'(AFULL_LVL);

    typedef enum logic [1:0] {
        IDLE,
        SEND_R,
        SEND_G,
        SEND_B
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [23:0]     mem [DEPTH];
    logic [23:0]     hold;
    logic            xfer;
    logic            pop;
    logic            push;
    logic            not_empty;

    assign xfer      = byte_valid && byte_ready;
    assign not_empty = (level != '0);

    // A pixel is loaded from IDLE or straight after its predecessor's B byte, so no bubble appears.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (not_empty) begin
                    pop        = 1'b1;
                    state_next = SEND_R;
                end
            end
            SEND_R: if (xfer) state_next = SEND_G;
            SEND_G: if (xfer) state_next = SEND_B;
            SEND_B: begin
                if (xfer) begin
                    if (not_empty) begin
                        pop        = 1'b1;
                        state_next = SEND_R;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign push = in_valid && ((level < DEPTH_L) || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            hold     <= '0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (in_valid && !push) overflow <= 1'b1;
        end
    end

    // Storage needs no reset; the pointers and level define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rgb_in;
    end

    always_comb begin
        byte_out = 8'h00;
        case (state)
            SEND_R:  byte_out = hold[23:16];
            SEND_G:  byte_out = hold[15:8];
            SEND_B:  byte_out = hold[7:0];
            default: byte_out = 8'h00;
        endcase
    end

    assign byte_valid  = (state != IDLE);
    assign byte_last   = (state == SEND_B);
    assign almost_full = (level >= AFULL_L);

endmodule

// File: tb/tb_rgb_byte_serializer.sv
// Self-checking bench for rgb_byte_serializer: a byte scoreboard filled when pixels are driven
// and drained by a monitor on every handshake, plus directed latency, stall, overflow and reset checks.
module tb_rgb_byte_serializer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [23:0] rgb_in;
    logic        almost_full;
    logic [3:0]  level;
    logic        overflow;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_last;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    rgb_byte_serializer #(.DEPTH(DEPTH), .AFULL_LVL(DEPTH - 2)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .rgb_in      (rgb_in),
        .almost_full (almost_full),
        .level       (level),
        .overflow    (overflow),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .byte_last   (byte_last)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [23:0] pixel, input logic ready,
                                 input logic expect_accept);
        exp_t e;
        in_valid   = valid;
        rgb_in     = pixel;
        byte_ready = ready;
        if (valid && expect_accept) begin
            e.data = pixel[23:16]; e.last = 1'b0; exp_q.push_back(e);
            e.data = pixel[15:8];  e.last = 1'b0; exp_q.push_back(e);
            e.data = pixel[7:0];   e.last = 1'b1; exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
        reset = 1'b1;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic waitDrain(input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || byte_valid) && n < max_cycles) begin
            tick();
            n++;
        end
        checkOutput("drain_done", {30'd0, exp_q.size() != 0, byte_valid}, 32'd0);
    endtask

    function automatic logic [23:0] seqPixel(input int k);
        return {8'(8'h10 + k), 8'(8'h20 + k), 8'(8'h30 + k)};
    endfunction

    // Every handshake must match the oldest expected byte; inputs only change just after rising edges.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && byte_valid && byte_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_byte", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                checkOutput("byte_out", 32'(byte_out), 32'(e.data));
                checkOutput("byte_last", 32'(byte_last), 32'(e.last));
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : main
        int   exp_lvl;
        int   valid_cycles;
        int   falls;
        int   max_level;
        logic prev_valid;

        reset = 1'b1;
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
        #2;
        checkOutput("rst_valid", 32'(byte_valid), 32'd0);
        checkOutput("rst_out", 32'(byte_out), 32'd0);
        checkOutput("rst_last", 32'(byte_last), 32'd0);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_afull", 32'(almost_full), 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Single pixel latency with the consumer always ready.
        $display("[TB] single pixel latency");
        applyStimulus(1'b1, 24'h1A2B3C, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
        checkOutput("lat_n_valid", 32'(byte_valid), 32'd0);
        checkOutput("lat_n_level", 32'(level), 32'd1);
        tick();
        checkOutput("lat_r_valid", 32'(byte_valid), 32'd1);
        checkOutput("lat_r_out", 32'(byte_out), 32'h1A);
        checkOutput("lat_r_last", 32'(byte_last), 32'd0);
        tick();
        checkOutput("lat_g_out", 32'(byte_out), 32'h2B);
        checkOutput("lat_g_last", 32'(byte_last), 32'd0);
        tick();
        checkOutput("lat_b_out", 32'(byte_out), 32'h3C);
        checkOutput("lat_b_last", 32'(byte_last), 32'd1);
        tick();
        checkOutput("lat_idle_valid", 32'(byte_valid), 32'd0);
        checkOutput("lat_idle_out", 32'(byte_out), 32'd0);

        // Consumer stalls for five cycles while the G byte is presented.
        $display("[TB] stall during G");
        applyStimulus(1'b1, 24'h1A2B3C, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_out", 32'(byte_out), 32'h2B);
            checkOutput("stall_valid", 32'(byte_valid), 32'd1);
        end
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
        tick();
        checkOutput("stall_b_out", 32'(byte_out), 32'h3C);
        checkOutput("stall_b_last", 32'(byte_last), 32'd1);
        tick();
        checkOutput("stall_idle_valid", 32'(byte_valid), 32'd0);

        // DEPTH+2 pixels back-to-back into a stalled consumer; the last one must be dropped.
        $display("[TB] overflow fill");
        for (int k = 0; k < DEPTH + 2; k++) begin
            applyStimulus(1'b1, seqPixel(k), 1'b0, k < DEPTH + 1);
            tick();
            exp_lvl = (k == 0) ? 1 : ((k > DEPTH) ? DEPTH : k);
            checkOutput("fill_level", 32'(level), 32'(exp_lvl));
            checkOutput("fill_afull", 32'(almost_full), 32'(exp_lvl >= DEPTH - 2));
            checkOutput("fill_overflow", 32'(overflow), 32'(k == DEPTH + 1));
        end
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
        checkOutput("fill_hold_out", 32'(byte_out), 32'h10);
        checkOutput("fill_hold_valid", 32'(byte_valid), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("fill_sticky_ovf", 32'(overflow), 32'd1);
        checkOutput("fill_level_hold", 32'(level), 32'(DEPTH));
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
        waitDrain(100);
        checkOutput("drain_sticky_ovf", 32'(overflow), 32'd1);
        checkOutput("drain_level", 32'(level), 32'd0);
        pulseReset();
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO: a write coincident with the B-byte pop must be accepted.
        $display("[TB] full with simultaneous pop");
        for (int k = 0; k < DEPTH + 1; k++) begin
            applyStimulus(1'b1, seqPixel(k + 64), 1'b0, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
        checkOutput("full_level", 32'(level), 32'(DEPTH));
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("full_in_b", 32'(byte_last), 32'd1);
        applyStimulus(1'b1, 24'hABCDEF, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
        checkOutput("full_pop_level", 32'(level), 32'(DEPTH));
        checkOutput("full_pop_ovf", 32'(overflow), 32'd0);
        checkOutput("full_pop_afull", 32'(almost_full), 32'd1);
        checkOutput("full_next_r", 32'(byte_out), 32'(8'h10 + 8'd65));
        waitDrain(200);

        // Steady stream of one pixel every three cycles must produce an unbroken byte stream.
        $display("[TB] steady stream");
        valid_cycles = 0;
        falls        = 0;
        max_level    = 0;
        prev_valid   = 1'b0;
        for (int p = 0; p < 503; p++) begin
            for (int c = 0; c < 3; c++) begin
                if (c == 0 && p < 500) applyStimulus(1'b1, 24'($urandom), 1'b1, 1'b1);
                else                   applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
                tick();
                if (byte_valid) valid_cycles++;
                if (prev_valid && !byte_valid) falls++;
                prev_valid = byte_valid;
                if (int'(level) > max_level) max_level = int'(level);
            end
        end
        checkOutput("stream_bytes", 32'(valid_cycles), 32'd1500);
        checkOutput("stream_bubbles", 32'(falls), 32'd1);
        checkOutput("stream_max_level", 32'(max_level), 32'd1);
        checkOutput("stream_overflow", 32'(overflow), 32'd0);
        checkOutput("stream_queue", 32'(exp_q.size()), 32'd0);

        // Reset during G with pixels still buffered, then a fresh pixel.
        $display("[TB] reset mid-pixel");
        applyStimulus(1'b1, 24'h112233, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 24'h778899, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 24'hAABBCC, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
        checkOutput("pre_rst_out", 32'(byte_out), 32'h22);
        checkOutput("pre_rst_level", 32'(level), 32'd2);
        reset = 1'b1;
        exp_q.delete();
        #1;
        checkOutput("mid_rst_valid", 32'(byte_valid), 32'd0);
        checkOutput("mid_rst_out", 32'(byte_out), 32'd0);
        checkOutput("mid_rst_level", 32'(level), 32'd0);
        checkOutput("mid_rst_last", 32'(byte_last), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 24'h445566, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
        tick();
        checkOutput("post_rst_r", 32'(byte_out), 32'h44);
        tick();
        checkOutput("post_rst_g", 32'(byte_out), 32'h55);
        tick();
        checkOutput("post_rst_b", 32'(byte_out), 32'h66);
        checkOutput("post_rst_last", 32'(byte_last), 32'd1);
        tick();
        checkOutput("post_rst_idle", 32'(byte_valid), 32'd0);
        checkOutput("post_rst_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
